imem_boot_loader: RTL and testbench

- Upstream boot stage for the single-cycle RV32I core.
- Accepts a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words, and writes them sequentially into instruction memory starting at byte address 0.
- Holds the core in reset until a complete, checksum-verified image has been written.
- Releases the core, which then fetches from PC 0.

---
 rtl/imem_boot_loader_if.sv | 26 ++
 rtl/imem_boot_loader.sv | 149 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_if.sv
// Byte-stream ingress and instruction-memory write bus of the boot loader.
// slave = loader side, master = byte source / memory / core side.
interface imem_boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  reload;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  core_reset;
    logic                  done;
    logic                  error;

    modport slave (
        input  rx_valid, rx_data, reload,
        output rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

    modport master (
        output rx_valid, rx_data, reload,
        input  rx_ready, imem_we, imem_addr, imem_wdata, core_reset, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte frame, writes it
// into instruction memory as little-endian words and holds the core in reset until verified.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MAX_WORDS  = 256
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [CNT_W-1:0]      wcnt_q, wcnt_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  core_reset_q, core_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  rx_ready_c;
    logic                  accept_c;
    logic [CNT_W-1:0]      n_full_c;
    logic                  last_word_c;

    assign rx_ready_c  = (state_q != S_DONE) && (state_q != S_ERR);
    assign accept_c    = bus.rx_valid && rx_ready_c;
    assign n_full_c    = {bus.rx_data, n_q[7:0]};
    assign last_word_c = (wcnt_q + CNT_W'(1)) == n_q;

    // State register and all datapath/output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LEN0;
            n_q          <= '0;
            wcnt_q       <= '0;
            bidx_q       <= '0;
            asm_q        <= '0;
            csum_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wcnt_q       <= wcnt_d;
            bidx_q       <= bidx_d;
            asm_q        <= asm_d;
            csum_q       <= csum_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state logic: every transition is gated by an accepted byte or a reload
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LEN0: if (accept_c) state_d = S_LEN1;
            S_LEN1: begin
                if (accept_c) begin
                    if (n_full_c > CNT_W'(MAX_WORDS)) state_d = S_ERR;
                    else if (n_full_c == '0)          state_d = S_CSUM;
                    else                              state_d = S_DATA;
                end
            end
            S_DATA: if (accept_c && (bidx_q == 2'd3) && last_word_c) state_d = S_CSUM;
            S_CSUM: if (accept_c) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
            S_DONE: if (bus.reload) state_d = S_LEN0;
            S_ERR:  if (bus.reload) state_d = S_LEN0;
            default: state_d = S_LEN0;
        endcase
    end

    // Datapath and registered outputs; status flags follow the upcoming state
    always_comb begin
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        bidx_d       = bidx_q;
        asm_d        = asm_q;
        csum_d       = csum_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        core_reset_d = (state_d != S_DONE);

        unique case (state_q)
            S_LEN0: if (accept_c) n_d = CNT_W'(bus.rx_data);
            S_LEN1: if (accept_c) n_d = n_full_c;
            S_DATA: begin
                if (accept_c) begin
                    csum_d = csum_q ^ bus.rx_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Byte 3 completes the word; strobe it at the current word address
                        we_d    = 1'b1;
                        wdata_d = {bus.rx_data, asm_q};
                        addr_d  = ADDR_WIDTH'({wcnt_q, 2'b00});
                        wcnt_d  = wcnt_q + CNT_W'(1);
                    end else begin
                        asm_d = {bus.rx_data, asm_q[23:8]};
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (bus.reload) begin
                    n_d    = '0;
                    wcnt_d = '0;
                    bidx_d = '0;
                    asm_d  = '0;
                    csum_d = '0;
                    addr_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.rx_ready   = rx_ready_c;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_reset = core_reset_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected writes go into a scoreboard queue,
// a negedge monitor pops and compares every imem_we strobe.
module tb_imem_boot_loader;
    localparam int unsigned AW = 10;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && bus.imem_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, none expected",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (bus.imem_addr !== e.addr || bus.imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr 0x%03h data 0x%08h expected addr 0x%03h data 0x%08h",
                             bus.imem_addr, bus.imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one byte and returns #1 after the handshake edge; rx_valid is left high
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: rx_ready stayed %b for byte 0x%02h", bus.rx_ready, b);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reload();
        bus.reload = 1'b1;
        @(posedge clk);
        #1;
        bus.reload = 1'b0;
    endtask

    task automatic push_nominal();
        exp_q.push_back('{addr: 10'h000, data: 32'h0050_0513});
        exp_q.push_back('{addr: 10'h004, data: 32'h00A0_0593});
    endtask

    // Nominal payload; checksum is the XOR of the 8 payload bytes = 0x70
    task automatic send_nominal(input logic [7:0] csum, input logic gappy);
        logic [7:0] pl[8];
        pl = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        send_byte(8'h02);
        send_byte(8'h00);
        for (int i = 0; i < 8; i++) begin
            send_byte(pl[i]);
            if (gappy) idle((i == 5) ? 5 : 1);
        end
        send_byte(csum);
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.reload   = 1'b0;
        #23;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Reset values
        chk("rst_rx_ready",   32'(bus.rx_ready),   32'd1);
        chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_error",      32'(bus.error),      32'd0);
        chk("rst_we",         32'(bus.imem_we),    32'd0);
        chk("rst_addr",       32'(bus.imem_addr),  32'd0);

        // Nominal load, back-to-back bytes
        push_nominal();
        send_nominal(8'h70, 1'b0);
        chk("nom_done",       32'(bus.done),       32'd1);
        chk("nom_core_reset", 32'(bus.core_reset), 32'd0);
        chk("nom_error",      32'(bus.error),      32'd0);
        chk("nom_rx_ready",   32'(bus.rx_ready),   32'd0);
        chk("nom_addr_hold",  32'(bus.imem_addr),  32'h004);
        idle(2);
        chk("nom_writes_left", 32'(exp_q.size()),  32'd0);
        pulse_reload();
        chk("rl_done",       32'(bus.done),       32'd0);
        chk("rl_core_reset", 32'(bus.core_reset), 32'd1);
        chk("rl_rx_ready",   32'(bus.rx_ready),   32'd1);
        chk("rl_addr",       32'(bus.imem_addr),  32'd0);

        // Checksum failure
        push_nominal();
        send_nominal(8'h00, 1'b0);
        chk("csf_error",      32'(bus.error),      32'd1);
        chk("csf_core_reset", 32'(bus.core_reset), 32'd1);
        chk("csf_rx_ready",   32'(bus.rx_ready),   32'd0);
        chk("csf_done",       32'(bus.done),       32'd0);
        idle(2);
        chk("csf_writes_left", 32'(exp_q.size()),  32'd0);
        pulse_reload();
        chk("csf_rl_error",    32'(bus.error),     32'd0);
        chk("csf_rl_rx_ready", 32'(bus.rx_ready),  32'd1);

        // Oversize image: N = 257
        send_byte(8'h01);
        send_byte(8'h01);
        bus.rx_valid = 1'b0;
        chk("ovs_error",    32'(bus.error),    32'd1);
        chk("ovs_rx_ready", 32'(bus.rx_ready), 32'd0);
        idle(3);
        pulse_reload();

        // Empty image, good and bad checksum
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        bus.rx_valid = 1'b0;
        chk("empty_done",       32'(bus.done),       32'd1);
        chk("empty_core_reset", 32'(bus.core_reset), 32'd0);
        pulse_reload();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        bus.rx_valid = 1'b0;
        chk("empty_bad_error", 32'(bus.error), 32'd1);
        chk("empty_bad_done",  32'(bus.done),  32'd0);
        pulse_reload();

        // Flow control: toggled valid plus a 5-cycle gap mid-word
        push_nominal();
        send_nominal(8'h70, 1'b1);
        chk("fc_done", 32'(bus.done), 32'd1);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("fc_done_rx_ready", 32'(bus.rx_ready), 32'd0);
        end
        bus.rx_valid = 1'b0;
        chk("fc_done_hold",    32'(bus.done),      32'd1);
        chk("fc_writes_left",  32'(exp_q.size()),  32'd0);
        pulse_reload();

        // Reset mid-load after the 2nd payload byte of word 1
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h05);
        bus.rx_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_we",         32'(bus.imem_we),    32'd0);
        chk("mid_rst_addr",       32'(bus.imem_addr),  32'd0);
        chk("mid_rst_wdata",      bus.imem_wdata,      32'd0);
        chk("mid_rst_core_reset", 32'(bus.core_reset), 32'd1);
        chk("mid_rst_done",       32'(bus.done),       32'd0);
        chk("mid_rst_rx_ready",   32'(bus.rx_ready),   32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_nominal();
        send_nominal(8'h70, 1'b0);
        chk("post_rst_done",  32'(bus.done),  32'd1);
        chk("post_rst_error", 32'(bus.error), 32'd0);
        idle(3);
        chk("final_writes_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
